crc_code_checker: RTL and testbench
===================================

# crc_code_checker

Read-side counterpart of the CRC encode path: accepts a 12-bit codeword fetched from the protected memory, recomputes the CRC-4 serially (one bit per clock), and presents the 8-bit data with error status. It sits between the memory read port and the consumer, mirroring the encoder/controller pair on the write side. An optional compile-time feature corrects any single-bit error.

## Interface
Parameters:
- none; data width 8, CRC width 4, polynomial x^4+x+1 (0x3) are fixed.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- read  input  1  start request; sampled only in IDLE
- code_in  input  12  codeword {data[7:0], crc[3:0]}, sampled with read
- addr_in  input  4  memory address, sampled with read
- data_out  output  8  checked (optionally corrected) data
- addr_out  output  4  address captured with the codeword
- syndrome  output  4  final CRC remainder; 0 means no error detected
- data_valid  output  1  one-cycle pulse: data_out/addr_out/flags valid
- error  output  1  syndrome nonzero; valid with data_valid
- corrected  output  1  single-bit error fixed (always 0 without CRC_CORRECT_EN)
- busy  output  1  high whenever state is not IDLE

## Operation
- States: IDLE, SHIFT, CHECK.
- IDLE: if read=1 at a rising edge, capture code_in into a 12-bit shift register, addr_in into addr register, clear LFSR s to 0, clear bit counter, go SHIFT. read=0: stay.
- SHIFT: each edge shift codeword MSB-first; b = shreg[11]; s <= {s[2:0], b} ^ (s[3] ? 4'b0011 : 4'b0000); counter increments. After 12th shift (counter 11 -> 12) go CHECK. Result: s = codeword mod g(x).
- CHECK (one cycle): register syndrome=s, error=(s!=0), data_out=codeword[11:4] (original copy held in a separate register), addr_out, assert data_valid for one cycle, go IDLE.
- Single-bit syndrome map (codeword bit i -> s): 0:1, 1:2, 2:4, 3:8, 4:3, 5:6, 6:C, 7:B, 8:5, 9:A, 10:7, 11:E. Remaining nonzero values (9, D, F) are uncorrectable.
- read while busy: ignored, no queueing.
- data_out, addr_out, syndrome, error, corrected hold their value until the next CHECK; data_valid is a pulse.

## Timing
- Reset (rst=0): state IDLE; all outputs 0; shift register, LFSR, counter cleared. Reset asserted mid-SHIFT/CHECK aborts; no data_valid is produced.
- read accepted at edge N; busy high from edge N through edge N+13; shifts at edges N+1..N+12; CHECK entered at N+12; data_valid high from edge N+13 to N+14.
- Latency read-accept -> data_valid = 13 cycles. Back-to-back: next read accepted at edge N+14 (while data_valid is high); throughput one codeword per 14 cycles.
- busy and data_valid are never high together.

## Configuration
- CRC_CORRECT_EN defined: in CHECK, a syndrome matching the map flips that codeword bit; if the bit lies in [11:4], data_out is the corrected data; corrected=1, error=1. Error in CRC bits [3:0]: corrected=1, data unchanged. Unmapped nonzero syndrome: error=1, corrected=0, raw data.
- CRC_CORRECT_EN undefined: no lookup logic; data_out is always raw data; corrected tied 0; error reflects syndrome!=0.

## Test plan
- Reset: hold rst=0 with read=1 -> all outputs 0, busy=0; release -> IDLE, no spurious data_valid.
- Clean word: code_in=0xA5B, addr_in=2 -> data_valid 13 cycles after accept, data_out=0xA5, addr_out=2, syndrome=0, error=0, corrected=0.
- Data-bit error: code_in=0xA4B (bit 4 flipped) -> syndrome=0x3, error=1; with CRC_CORRECT_EN data_out=0xA5, corrected=1; without, data_out=0xA4, corrected=0.
- Double error: code_in=0xA52 (bits 0 and 3 flipped) -> syndrome=0x9, error=1, corrected=0, data_out=0xA5 in both builds.
- Busy rules: pulse read at accept+3 with a different code_in -> ignored, results match first word; second read at accept+14 -> accepted, data_valid at accept+27.
- Abort: assert rst at accept+6 -> outputs 0 immediately; no data_valid; fresh read afterwards completes normally.

Source files
------------

// File: rtl/crc_code_checker.sv
// -----------------------------------------------------------------------------
// crc_code_checker
//
// Read-side CRC-4 checker. Accepts a 12-bit codeword {data[7:0], crc[3:0]}
// from the protected memory and recomputes the remainder serially, one bit per
// clock, MSB first, with g(x) = x^4 + x + 1. It then presents the 8-bit data
// together with the address and the error status.
//
// Configuration macro:
//   CRC_CORRECT_EN  when defined, any single-bit error is corrected by looking
//                   up the syndrome. When undefined, there is no lookup logic,
//                   data_out is always the raw data and corrected is tied to 0.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   read        start request, sampled only while idle
//   code_in     codeword {data[7:0], crc[3:0]}, sampled with read
//   addr_in     memory address, sampled with read
//   data_out    checked (optionally corrected) data, held until next result
//   addr_out    address captured with the codeword, held
//   syndrome    final CRC remainder, 0 = no error detected, held
//   data_valid  one-cycle pulse marking a new result
//   error       syndrome != 0, held
//   corrected   single-bit error was fixed, held
//   busy        high whenever a codeword is in flight
//
// Latency: a read accepted at edge N gives data_valid high from N+13 to N+14.
// -----------------------------------------------------------------------------
module crc_code_checker (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [11:0] code_in,
  input  logic [3:0]  addr_in,
  output logic [7:0]  data_out,
  output logic [3:0]  addr_out,
  output logic [3:0]  syndrome,
  output logic        data_valid,
  output logic        error,
  output logic        corrected,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Low-order terms of g(x); the x^4 term is implied by the feedback bit.
  localparam logic [3:0] POLY = 4'h3;

  state_e      state_q, state_d;
  logic [11:0] shreg_q, shreg_d;   // codeword being shifted out MSB first
  logic [7:0]  data_q,  data_d;    // untouched copy of the data field
  logic [3:0]  addr_q,  addr_d;
  logic [3:0]  lfsr_q,  lfsr_d;    // running remainder
  logic [3:0]  cnt_q,   cnt_d;     // shifts done so far

  logic [7:0]  data_out_q,  data_out_d;
  logic [3:0]  addr_out_q,  addr_out_d;
  logic [3:0]  syndrome_q,  syndrome_d;
  logic        error_q,     error_d;
  logic        corrected_q, corrected_d;
  logic        valid_q,     valid_d;

  // Result of the syndrome lookup, used only in CHECK.
  logic [7:0]  fixed_data;
  logic        fix_hit;

`ifdef CRC_CORRECT_EN
  // One-hot mask of the codeword bit whose single-bit error yields the
  // current remainder. Remainders 9, D and F are not produced by any single
  // bit, so they (and 0) give an empty mask.
  logic [11:0] flip_mask;

  always_comb begin
    unique case (lfsr_q)
      4'h1:    flip_mask = 12'h001;
      4'h2:    flip_mask = 12'h002;
      4'h4:    flip_mask = 12'h004;
      4'h8:    flip_mask = 12'h008;
      4'h3:    flip_mask = 12'h010;
      4'h6:    flip_mask = 12'h020;
      4'hC:    flip_mask = 12'h040;
      4'hB:    flip_mask = 12'h080;
      4'h5:    flip_mask = 12'h100;
      4'hA:    flip_mask = 12'h200;
      4'h7:    flip_mask = 12'h400;
      4'hE:    flip_mask = 12'h800;
      default: flip_mask = 12'h000;
    endcase
  end

  // A hit in the CRC field [3:0] still counts as corrected, but leaves the
  // data unchanged.
  assign fix_hit    = |flip_mask;
  assign fixed_data = data_q ^ flip_mask[11:4];
`else
  assign fix_hit    = 1'b0;
  assign fixed_data = data_q;
`endif

  // Next-state and datapath logic.
  // NOTE: every signal is given a default first, so no path through the case
  // leaves one unassigned and no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    addr_d      = addr_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    addr_out_d  = addr_out_q;
    syndrome_d  = syndrome_q;
    error_d     = error_q;
    corrected_d = corrected_q;
    valid_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (read) begin
          shreg_d = code_in;
          data_d  = code_in[11:4];
          addr_d  = addr_in;
          lfsr_d  = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        shreg_d = {shreg_q[10:0], 1'b0};
        lfsr_d  = {lfsr_q[2:0], shreg_q[11]} ^ (lfsr_q[3] ? POLY : 4'h0);
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd11) state_d = CHECK;
      end

      CHECK: begin
        syndrome_d  = lfsr_q;
        error_d     = |lfsr_q;
        corrected_d = fix_hit;
        data_out_d  = fixed_data;
        addr_out_d  = addr_q;
        valid_d     = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the values from before this edge.
  // NOTE: every register, including the shift register and the data copy,
  // is reset; a reset mid-transfer then leaves nothing stale behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      lfsr_q      <= '0;
      cnt_q       <= '0;
      data_out_q  <= '0;
      addr_out_q  <= '0;
      syndrome_q  <= '0;
      error_q     <= 1'b0;
      corrected_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      addr_out_q  <= addr_out_d;
      syndrome_q  <= syndrome_d;
      error_q     <= error_d;
      corrected_q <= corrected_d;
      valid_q     <= valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign addr_out   = addr_out_q;
  assign syndrome   = syndrome_q;
  assign error      = error_q;
  assign corrected  = corrected_q;
  assign data_valid = valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_crc_code_checker.sv
// -----------------------------------------------------------------------------
// tb_crc_code_checker
//
// Self-checking bench for crc_code_checker. The reference model computes the
// remainder by polynomial long division and finds correctable errors by
// searching all twelve single-bit error patterns. Works for both builds
// (with and without CRC_CORRECT_EN).
// -----------------------------------------------------------------------------
module tb_crc_code_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic [11:0] code_in;
  logic [3:0]  addr_in;
  logic [7:0]  data_out;
  logic [3:0]  addr_out;
  logic [3:0]  syndrome;
  logic        data_valid;
  logic        error;
  logic        corrected;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Expected values of the most recent result, used for the hold check.
  logic [7:0] last_data;
  logic [3:0] last_addr;

  crc_code_checker dut (
    .clk        (clk),
    .rst        (rst),
    .read       (read),
    .code_in    (code_in),
    .addr_in    (addr_in),
    .data_out   (data_out),
    .addr_out   (addr_out),
    .syndrome   (syndrome),
    .data_valid (data_valid),
    .error      (error),
    .corrected  (corrected),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Remainder of the 12-bit codeword polynomial divided by x^4 + x + 1.
  function automatic logic [3:0] crc_mod(input logic [11:0] cw);
    logic [11:0] r;
    r = cw;
    for (int b = 11; b >= 4; b--)
      if (r[b]) r = r ^ (12'h013 << (b - 4));
    return r[3:0];
  endfunction

  function automatic logic [11:0] make_code(input logic [7:0] d);
    return {d, crc_mod({d, 4'h0})};
  endfunction

  // Expected {data, syndrome, error, corrected} for a received codeword.
  task automatic model(input logic [11:0] cw, output logic [7:0] d,
                       output logic [3:0] s, output logic e, output logic c);
    logic [11:0] fixed;
    s     = crc_mod(cw);
    e     = (s != 4'h0);
    c     = 1'b0;
    fixed = cw;
`ifdef CRC_CORRECT_EN
    if (e) begin
      for (int i = 0; i < 12; i++) begin
        if (crc_mod(12'(1) << i) == s) begin
          fixed = cw ^ (12'(1) << i);
          c     = 1'b1;
        end
      end
    end
`endif
    d = fixed[11:4];
  endtask

  // ---------------- protocol monitors ----------------
  logic prev_dv = 1'b0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (busy && data_valid) check("busy_dv_overlap", {busy, data_valid}, 2'b00);
      if (prev_dv && data_valid) check("dv_pulse_width", 2, 1);
    end
    prev_dv = data_valid;
  end

  // ---------------- stimulus ----------------
  // Issue one read (accepted at the next edge) and check its result. Returns
  // 1 ns after the edge where data_valid rises, so an immediate follow-up call
  // gets accepted on the very next edge. poke pulses a different read at
  // accept+3, which must be ignored.
  task automatic run_word(input logic [11:0] cw, input logic [3:0] addr, input bit poke);
    logic [7:0] ed;
    logic [3:0] es;
    logic       ee, ec;
    int         n;
    bit         seen;
    model(cw, ed, es, ee, ec);
    code_in = cw;
    addr_in = addr;
    read    = 1'b1;
    @(posedge clk); #1;
    read    = 1'b0;
    check("busy_after_accept", busy, 1);
    n    = 0;
    seen = 0;
    while (!seen && n < 30) begin
      if (poke && n == 2) begin
        read    = 1'b1;
        code_in = ~cw;
        addr_in = ~addr;
      end
      if (poke && n == 3) read = 1'b0;
      @(posedge clk); #1;
      n++;
      if (data_valid) seen = 1;
    end
    check("dv_latency", n, 13);
    if (seen) begin
      check("busy_low_at_dv", busy, 0);
      check("data_out", data_out, ed);
      check("addr_out", addr_out, addr);
      check("syndrome", syndrome, es);
      check("error", error, ee);
      check("corrected", corrected, ec);
    end
    last_data = ed;
    last_addr = addr;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Count data_valid pulses seen over a window; none are expected.
  task automatic expect_quiet(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (data_valid) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {data_out, addr_out, syndrome, data_valid, error, corrected, busy}, 0);
  endtask

  initial begin
    logic [7:0]  d;
    logic [11:0] cw;
    int          nerr;
    int          b1, b2;

    // Reset held with read asserted: everything stays at zero.
    rst     = 1'b0;
    read    = 1'b1;
    code_in = 12'hFFF;
    addr_in = 4'hF;
    idle(4);
    check_all_zero("reset_outputs");
    read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    expect_quiet("no_dv_after_reset", 16);
    check_all_zero("idle_after_reset");

    // Directed words from the test plan.
    run_word(12'hA5B, 4'h2, 0);
    check("clean_syndrome", syndrome, 4'h0);
    check("clean_data", data_out, 8'hA5);

    idle(2);
    run_word(12'hA4B, 4'h5, 0);
    check("bit4_syndrome", syndrome, 4'h3);
`ifdef CRC_CORRECT_EN
    check("bit4_data", data_out, 8'hA5);
    check("bit4_corrected", corrected, 1);
`else
    check("bit4_data", data_out, 8'hA4);
    check("bit4_corrected", corrected, 0);
`endif

    idle(1);
    run_word(12'hA52, 4'h7, 0);
    check("double_syndrome", syndrome, 4'h9);
    check("double_corrected", corrected, 0);
    check("double_data", data_out, 8'hA5);

    // Busy rules: a read at accept+3 is ignored; a back-to-back read is
    // accepted at accept+14 and completes at accept+27.
    idle(3);
    run_word(make_code(8'h3C), 4'h9, 1);
    run_word(make_code(8'hC3) ^ 12'h100, 4'h4, 0);

    // Hold: results stay put across idle cycles.
    idle(5);
    check("hold_data", data_out, last_data);
    check("hold_addr", addr_out, last_addr);

    // Abort mid-shift.
    code_in = 12'h5A5;
    addr_in = 4'hB;
    read    = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    idle(6);
    rst = 1'b0;
    #1;
    check_all_zero("abort_outputs");
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    expect_quiet("no_dv_after_abort", 20);
    run_word(make_code(8'h81), 4'h1, 0);

    // Randomized words with 0, 1 or 2 bit errors and random spacing.
    for (int k = 0; k < 60; k++) begin
      d    = 8'($urandom);
      cw   = make_code(d);
      nerr = $urandom_range(0, 2);
      b1   = $urandom_range(0, 11);
      b2   = (b1 + $urandom_range(1, 11)) % 12;
      if (nerr >= 1) cw[b1] = ~cw[b1];
      if (nerr == 2) cw[b2] = ~cw[b2];
      run_word(cw, 4'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) != 0) begin
        idle($urandom_range(1, 4));
        check("rand_hold_data", data_out, last_data);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
